// File: rtl/spi_pkg.sv
// Shared constants for the SPI master peripheral: register offsets,
// register bit positions and the transfer FSM state type.
package spi_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;

    localparam int CTRL_DIV_LSB  = 0;
    localparam int CTRL_CPOL     = 16;
    localparam int CTRL_CPHA     = 17;
    localparam int CTRL_CS       = 24;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_OVERRUN  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing for one byte: a half-period counter running 0..DIV and a
// 16-edge counter, held cleared whenever the transfer is not active.
module spi_clkgen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick,
    output logic                 o_odd,
    output logic                 o_last
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [3:0]           r_edge;

    assign o_tick = i_en && (r_cnt == i_div);
    // r_edge counts edges already produced, so an even count means the
    // edge about to happen is the 1st, 3rd, ...
    assign o_odd  = ~r_edge[0];
    assign o_last = (r_edge == 4'd15);

    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_cnt  <= '0;
            r_edge <= '0;
        end else if (o_tick) begin
            r_cnt  <= '0;
            r_edge <= r_edge + 4'd1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Memory-mapped SPI master: one byte per transfer, MSB first, all four
// modes, programmable SCLK divider and software-owned chip select.
module spi_master
    import spi_pkg::*;
#(
    parameter int                   DIV_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = 16'd17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic        sclk_out,
    output logic        mosi_out,
    input  logic        miso_in,
    output logic        csn_out
);

    spi_state_t           r_state;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_cpol;
    logic                 r_cpha;
    logic                 r_cs;
    logic                 r_overrun;
    logic                 r_rx_valid;
    logic [7:0]           r_rx_byte;
    logic [7:0]           r_tx;
    logic [7:0]           r_rx;
    logic                 r_sclk;
    logic                 r_mosi;

    logic [1:0]  w_reg;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_data_wr;
    logic        w_data_rd;
    logic        w_ovr_clr;
    logic [15:0] w_div16;
    logic [15:0] w_div_new;
    logic        w_tick;
    logic        w_odd;
    logic        w_last;
    logic        w_sample;
    logic [7:0]  w_rx_next;
    logic        w_unused;

    assign w_reg     = address_in[3:2];
    assign w_busy    = (r_state == SHIFT);
    assign w_ctrl_wr = sel_in && (w_reg == REG_CTRL);
    assign w_data_wr = sel_in && (w_reg == REG_DATA) && write_mask_in[0];
    assign w_data_rd = sel_in && read_in && (w_reg == REG_DATA);
    assign w_ovr_clr = sel_in && (w_reg == REG_STATUS) && write_mask_in[0]
                       && write_value_in[STAT_OVERRUN];

    assign w_div16   = 16'(r_div);
    assign w_div_new = {write_mask_in[1] ? write_value_in[15:8] : w_div16[15:8],
                        write_mask_in[0] ? write_value_in[7:0]  : w_div16[7:0]};

    assign w_unused  = ^{address_in[31:4], address_in[1:0],
                         write_value_in[31:25], write_value_in[23:18]};

    spi_clkgen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clkgen (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_busy),
        .i_div  (r_div),
        .o_tick (w_tick),
        .o_odd  (w_odd),
        .o_last (w_last)
    );

    // CPHA=0 samples on odd edges, CPHA=1 on even edges; the rest shift.
    assign w_sample  = w_tick && (w_odd ^ r_cpha);
    assign w_rx_next = {r_rx[6:0], miso_in};

    // Mode/divider are frozen during a transfer; CS stays writable so
    // software can frame multi-byte sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div     <= DIV_RESET;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_cs      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_ctrl_wr && !w_busy) begin
                if (write_mask_in[0] || write_mask_in[1])
                    r_div <= DIV_WIDTH'(w_div_new);
                if (write_mask_in[2]) begin
                    r_cpol <= write_value_in[CTRL_CPOL];
                    r_cpha <= write_value_in[CTRL_CPHA];
                end
            end
            if (w_ctrl_wr && write_mask_in[3])
                r_cs <= write_value_in[CTRL_CS];
            if (w_data_wr && w_busy)
                r_overrun <= 1'b1;
            else if (w_ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rx_byte  <= 8'h00;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_data_rd)
                r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= r_cpol;
                    if (w_data_wr) begin
                        r_state <= SHIFT;
                        r_mosi  <= write_value_in[7];
                        // CPHA=0 has already presented bit 7, so the first
                        // shift edge must move on to bit 6.
                        r_tx    <= r_cpha ? write_value_in[7:0]
                                          : {write_value_in[6:0], 1'b0};
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end else begin
                            r_mosi <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                        if (w_last) begin
                            r_state    <= IDLE;
                            r_rx_byte  <= w_sample ? w_rx_next : r_rx;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        read_value_out = 32'h0;
        if (sel_in) begin
            case (w_reg)
                REG_CTRL: begin
                    read_value_out[CTRL_DIV_LSB +: 16] = w_div16;
                    read_value_out[CTRL_CPOL]          = r_cpol;
                    read_value_out[CTRL_CPHA]          = r_cpha;
                    read_value_out[CTRL_CS]            = r_cs;
                end
                REG_STATUS: begin
                    read_value_out[STAT_BUSY]     = w_busy;
                    read_value_out[STAT_RX_VALID] = r_rx_valid;
                    read_value_out[STAT_OVERRUN]  = r_overrun;
                end
                REG_DATA: read_value_out[7:0] = r_rx_byte;
                default:  read_value_out = 32'h0;
            endcase
        end
    end

    assign ready_out = sel_in;
    assign sclk_out  = r_sclk;
    assign mosi_out  = r_mosi;
    assign csn_out   = ~r_cs;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: bus tasks, an SPI slave model on the pins, and a
// scoreboard of expected MOSI bytes and expected received bytes.
`timescale 1ns/1ps
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = 32'h0;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] wd = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        csn;

    int n_total = 0;
    int n_bad   = 0;

    // scoreboard
    logic [7:0] q_mosi[$];
    logic [7:0] q_rx[$];

    // stimulus-owned slave configuration
    logic       tb_cpha = 1'b0;
    logic       tb_loop = 1'b0;
    logic [7:0] slv_byte = 8'h00;
    int         start_req = 0;

    // monitor-owned slave state
    int         seen_req = 0;
    logic       slv_active = 1'b0;
    logic [8:0] slv_sh = 9'h0;
    int         mon_edges = 0;
    int         mon_rises = 0;
    logic [7:0] mon_cap = 8'h00;
    logic       prev_sclk = 1'b0;

    always #5 clk = ~clk;

    assign miso = tb_loop ? mosi : slv_sh[8];

    spi_master dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (adr),
        .sel_in         (sel),
        .read_in        (rd),
        .read_value_out (rdata),
        .write_mask_in  (mask),
        .write_value_in (wd),
        .ready_out      (ready),
        .sclk_out       (sclk),
        .mosi_out       (mosi),
        .miso_in        (miso),
        .csn_out        (csn)
    );

    // SPI slave: drives MISO on shift edges, captures MOSI on sample edges.
    always @(posedge clk) begin
        #1;
        if (start_req != seen_req) begin
            seen_req   = start_req;
            slv_active = 1'b1;
            mon_edges  = 0;
            mon_rises  = 0;
            mon_cap    = 8'h00;
            slv_sh     = tb_cpha ? {1'b0, slv_byte} : {slv_byte, 1'b0};
        end
        if (slv_active && (sclk != prev_sclk)) begin
            mon_edges++;
            if (sclk) mon_rises++;
            if ((mon_edges % 2 == 1) ^ tb_cpha)
                mon_cap = {mon_cap[6:0], mosi};
            else
                slv_sh = {slv_sh[7:0], 1'b0};
            if (mon_edges == 16) slv_active = 1'b0;
        end
        prev_sclk = sclk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        sel = 1'b1; rd = 1'b0; adr = a; wd = d; mask = m;
        @(posedge clk); #1;
        sel = 1'b0; mask = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1; rd = 1'b1; adr = a; mask = 4'h0;
        #1 d = rdata;
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        chk(tag, d, exp);
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sbyte, input logic loopb);
        tb_loop  = loopb;
        slv_byte = sbyte;
        start_req++;
        q_mosi.push_back(tx);
        q_rx.push_back(loopb ? tx : sbyte);
        bus_write(32'h8, {24'h0, tx}, 4'h1);
    endtask

    // Polls STATUS.BUSY every cycle, counting busy cycles, with a bound.
    task automatic wait_done(output int cyc);
        int n;
        sel = 1'b1; rd = 1'b1; adr = 32'h4; mask = 4'h0;
        #1;
        cyc = 0;
        n = 0;
        while (rdata[0] && n < 3000) begin
            cyc++;
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", (n < 3000), 1);
        sel = 1'b0; rd = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int          cyc;
        logic [31:0] cw;
        logic [7:0]  tx;
        logic [7:0]  dummy;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // reset state
        chk("rst_csn", csn, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        rd_chk("rst_ctrl", 32'h0, 32'h0000_0011);
        rd_chk("rst_status", 32'h4, 32'h0);
        rd_chk("rst_data", 32'h8, 32'h0);
        rd_chk("rst_resv", 32'hC, 32'h0);

        // unselected accesses do nothing and read zero
        sel = 1'b0; rd = 1'b1; adr = 32'h0; mask = 4'hF; wd = 32'hFFFF_FFFF;
        #1;
        chk("nosel_rdata", rdata, 0);
        chk("nosel_ready", ready, 0);
        @(posedge clk); #1;
        adr = 32'h8;
        @(posedge clk); #1;
        rd = 1'b0; mask = 4'h0;
        sel = 1'b1; adr = 32'h4;
        #1 chk("sel_ready", ready, 1);
        sel = 1'b0;
        @(posedge clk); #1;
        rd_chk("nosel_ctrl", 32'h0, 32'h0000_0011);
        rd_chk("nosel_status", 32'h4, 32'h0);

        // lane-3-only write touches CS alone
        bus_write(32'h0, 32'hFFFF_FFFF, 4'b1000);
        rd_chk("mask_ctrl", 32'h0, 32'h0100_0011);
        chk("mask_csn", csn, 0);

        // mode 0, DIV=0, loopback
        bus_write(32'h0, 32'h0100_0000, 4'hF);
        tb_cpha = 1'b0;
        start_xfer(8'hA5, 8'h00, 1'b1);
        wait_done(cyc);
        chk("m0_busy_cycles", cyc, 16);
        chk("m0_rises", mon_rises, 8);
        chk("m0_mosi", mon_cap, q_mosi.pop_front());
        rd_chk("m0_status", 32'h4, 32'h2);
        rd_chk("m0_data", 32'h8, {24'h0, q_rx.pop_front()});
        rd_chk("m0_status_clr", 32'h4, 32'h0);

        // modes 1..3, DIV=3, slave returns 0x3C
        for (int m = 1; m < 4; m++) begin
            cw = 32'h0100_0003;
            if (m >= 2) cw[16] = 1'b1;
            if (m % 2 == 1) cw[17] = 1'b1;
            tb_cpha = cw[17];
            bus_write(32'h0, cw, 4'hF);
            @(posedge clk); #1;
            chk("mode_idle_sclk", sclk, cw[16]);
            tx = 8'h5A ^ 8'(m);
            start_xfer(tx, 8'h3C, 1'b0);
            wait_done(cyc);
            chk("mode_busy_cycles", cyc, 64);
            chk("mode_rises", mon_rises, 8);
            chk("mode_mosi", mon_cap, q_mosi.pop_front());
            chk("mode_end_sclk", sclk, cw[16]);
            rd_chk("mode_rx", 32'h8, {24'h0, q_rx.pop_front()});
        end

        // DATA write while busy: overrun, original transfer unaffected
        bus_write(32'h0, 32'h0100_0003, 4'hF);
        tb_cpha = 1'b0;
        start_xfer(8'hC7, 8'h3C, 1'b0);
        bus_write(32'h8, 32'h11, 4'h1);
        wait_done(cyc);
        chk("ovr_mosi", mon_cap, q_mosi.pop_front());
        rd_chk("ovr_status", 32'h4, 32'h6);
        rd_chk("ovr_data", 32'h8, {24'h0, q_rx.pop_front()});
        bus_write(32'h4, 32'h4, 4'h1);
        rd_chk("ovr_cleared", 32'h4, 32'h0);

        // CTRL write while busy: only CS changes
        start_xfer(8'h81, 8'h42, 1'b0);
        bus_write(32'h0, 32'h0003_0007, 4'hF);
        chk("busy_csn", csn, 1);
        wait_done(cyc);
        chk("busy_ctrl_mosi", mon_cap, q_mosi.pop_front());
        rd_chk("busy_ctrl", 32'h0, 32'h0000_0003);
        rd_chk("busy_ctrl_rx", 32'h8, {24'h0, q_rx.pop_front()});
        rd_chk("busy_ctrl_status", 32'h4, 32'h0);

        // second completion with RX_VALID still set overwrites, no overrun
        bus_write(32'h0, 32'h0100_0003, 4'hF);
        start_xfer(8'h33, 8'h99, 1'b0);
        wait_done(cyc);
        chk("ow_mosi1", mon_cap, q_mosi.pop_front());
        dummy = q_rx.pop_front();
        start_xfer(8'h44, 8'hE1, 1'b0);
        wait_done(cyc);
        chk("ow_mosi2", mon_cap, q_mosi.pop_front());
        rd_chk("ow_status", 32'h4, 32'h2);
        rd_chk("ow_data", 32'h8, {24'h0, q_rx.pop_front()});

        // reset in the middle of a DIV=1 transfer
        bus_write(32'h0, 32'h0100_0001, 4'hF);
        start_xfer(8'h96, 8'h00, 1'b1);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rstx_sclk", sclk, 0);
        chk("rstx_csn", csn, 1);
        chk("rstx_mosi", mosi, 0);
        rd_chk("rstx_status_in_rst", 32'h4, 32'h0);
        reset = 1'b0;
        dummy = q_mosi.pop_front();
        dummy = q_rx.pop_front();
        repeat (20) @(posedge clk);
        #1;
        rd_chk("rstx_status", 32'h4, 32'h0);
        rd_chk("rstx_data", 32'h8, 32'h0);
        rd_chk("rstx_ctrl", 32'h0, 32'h0000_0011);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
